ctrl_fsm: RTL

Multi-cycle control unit directly upstream of the 16-bit datapath; consumes the fetched instruction word (im_out) and the ALU zero flag, and drives every datapath control input (op, mux selects, wrf, wdm, store). Sequences each instruction through FETCH/EXEC/MEM/WB states so register, memory and PC writes each pulse exactly once per instruction.

---
 rtl/ctrl_fsm_if.sv | 48 ++++
 rtl/ctrl_fsm.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_fsm_if.sv
// ----------------------------------------------------------------------------
// ctrl_fsm_if
// Groups everything between the multi-cycle control unit and the 16-bit
// datapath into one bundle.
//   master modport : control unit side (consumes en/im_out/zero, drives controls)
//   slave  modport : datapath / environment side
// Signals:
//   en          run enable, looked at only while fetching
//   im_out[15:0] instruction word from instruction memory
//   zero        ALU zero flag
//   op[3:0]     ALU operation
//   sIn1_Alu, sIn2_Alu, sWn_Rf, sWd_Rf, sRn2_Rf, sIn0_Mux, sIn_Pc, sExt10
//               datapath mux selects
//   wrf, wdm, store  register-file write, data-memory write, PC write
//   instr_done  one-cycle pulse in the last state of each instruction
//   halted      illegal-instruction halt flag
// ----------------------------------------------------------------------------
interface ctrl_fsm_if;
  logic        en;
  logic [15:0] im_out;
  logic        zero;
  logic [3:0]  op;
  logic        sIn1_Alu;
  logic        sIn2_Alu;
  logic        sWn_Rf;
  logic        sWd_Rf;
  logic        sRn2_Rf;
  logic        sIn0_Mux;
  logic        sIn_Pc;
  logic        sExt10;
  logic        wrf;
  logic        wdm;
  logic        store;
  logic        instr_done;
  logic        halted;

  modport master (
    input  en, im_out, zero,
    output op, sIn1_Alu, sIn2_Alu, sWn_Rf, sWd_Rf, sRn2_Rf, sIn0_Mux,
           sIn_Pc, sExt10, wrf, wdm, store, instr_done, halted
  );

  modport slave (
    output en, im_out, zero,
    input  op, sIn1_Alu, sIn2_Alu, sWn_Rf, sWd_Rf, sRn2_Rf, sIn0_Mux,
           sIn_Pc, sExt10, wrf, wdm, store, instr_done, halted
  );
endinterface

// File: rtl/ctrl_fsm.sv
// ----------------------------------------------------------------------------
// ctrl_fsm
// Multi-cycle control unit for the 16-bit datapath. Each instruction walks
// FETCH -> EXEC -> (MEM, loads/stores only) -> WB -> FETCH so that the
// register-file write, data-memory write and PC write each pulse exactly
// once per instruction. All outputs are Moore-decoded from state + IR; the
// only exception is the branch-taken select, which follows the ALU zero
// flag combinationally while in WB.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous, active-low reset
//   bus   ctrl_fsm_if.master (en, im_out, zero in; all datapath controls out)
// Build option:
//   CTRL_ILLEGAL_HALT_EN  when defined, an illegal opcode parks the FSM in a
//                         HALT state (halted=1) until reset; otherwise the
//                         illegal opcode runs as a NOP and halted is 0.
// ----------------------------------------------------------------------------
module ctrl_fsm #(
  parameter logic [3:0] ALU_ADD = 4'h0,
  parameter logic [3:0] ALU_SUB = 4'h1,
  parameter logic [3:0] ALU_OR  = 4'h3
) (
  input  logic       clk,
  input  logic       rst,
  ctrl_fsm_if.master bus
);

  localparam logic [2:0] S_FETCH = 3'd0;
  localparam logic [2:0] S_EXEC  = 3'd1;
  localparam logic [2:0] S_MEM   = 3'd2;
  localparam logic [2:0] S_WB    = 3'd3;
`ifdef CTRL_ILLEGAL_HALT_EN
  localparam logic [2:0] S_HALT  = 3'd4;
`endif

  localparam logic [5:0] OPC_AR   = 6'h00;
  localparam logic [5:0] OPC_ADDI = 6'h01;
  localparam logic [5:0] OPC_ORI  = 6'h02;
  localparam logic [5:0] OPC_BEQ  = 6'h03;
  localparam logic [5:0] OPC_BNE  = 6'h04;
  localparam logic [5:0] OPC_LW   = 6'h05;
  localparam logic [5:0] OPC_SW   = 6'h06;
  localparam logic [5:0] OPC_J    = 6'h07;

  logic [2:0]  r_state;
  logic [15:0] r_ir;

  logic [5:0]  w_opc;
  logic        w_isMem;
  logic        w_active;
  logic        w_inWb;
  logic        w_unused;

  logic [3:0]  w_op;
  logic        w_sIn1;
  logic        w_sIn2;
  logic        w_sWn;
  logic        w_sWd;
  logic        w_sRn2;
  logic        w_sIn0;
  logic        w_sInPc;
  logic        w_sExt10;
  logic        w_wrf;
  logic        w_wdm;
  logic        w_halted;

  assign w_opc    = r_ir[15:10];
  assign w_isMem  = (w_opc == OPC_LW) || (w_opc == OPC_SW);
  assign w_active = (r_state == S_EXEC) || (r_state == S_MEM) || (r_state == S_WB);
  assign w_inWb   = (r_state == S_WB);
  // Register-field bits belong to the datapath; the controller never decodes them.
  assign w_unused = ^r_ir[9:4];

`ifdef CTRL_ILLEGAL_HALT_EN
  logic w_illegal;
  assign w_illegal = (w_opc > OPC_J);
`endif

  // The IR is captured only on the FETCH->EXEC edge so decode stays stable
  // for the whole instruction even if instruction memory moves on.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_FETCH;
      r_ir    <= 16'h0000;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (bus.en) begin
            r_ir    <= bus.im_out;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
`ifdef CTRL_ILLEGAL_HALT_EN
          if (w_illegal)
            r_state <= S_HALT;
          else
`endif
            r_state <= w_isMem ? S_MEM : S_WB;
        end
        S_MEM:   r_state <= S_WB;
        S_WB:    r_state <= S_FETCH;
`ifdef CTRL_ILLEGAL_HALT_EN
        S_HALT:  r_state <= S_HALT;
`endif
        default: r_state <= S_FETCH;
      endcase
    end
  end

  // Selects are held for the whole EXEC..WB window; in FETCH (and HALT)
  // everything rests at 0. Illegal opcodes fall through with all selects 0.
  always_comb begin
    w_op     = 4'h0;
    w_sIn1   = 1'b0;
    w_sIn2   = 1'b0;
    w_sWn    = 1'b0;
    w_sWd    = 1'b0;
    w_sRn2   = 1'b0;
    w_sInPc  = 1'b0;
    w_sExt10 = 1'b0;
    if (w_active) begin
      case (w_opc)
        OPC_AR: begin
          w_op  = r_ir[3:0];
          w_sWn = 1'b1;
        end
        OPC_ADDI: begin
          w_op     = ALU_ADD;
          w_sExt10 = 1'b1;
          w_sIn2   = 1'b1;
          w_sWn    = 1'b1;
        end
        OPC_ORI: begin
          w_op   = ALU_OR;
          w_sIn2 = 1'b1;
          w_sWn  = 1'b1;
        end
        OPC_BEQ, OPC_BNE: begin
          w_op     = ALU_SUB;
          w_sRn2   = 1'b1;
          w_sExt10 = 1'b1;
        end
        OPC_LW: begin
          w_op     = ALU_ADD;
          w_sExt10 = 1'b1;
          w_sIn2   = 1'b1;
          w_sWn    = 1'b1;
          w_sWd    = 1'b1;
        end
        OPC_SW: begin
          w_op     = ALU_ADD;
          w_sExt10 = 1'b1;
          w_sIn2   = 1'b1;
          w_sRn2   = 1'b1;
        end
        OPC_J: begin
          w_sInPc = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Strobes: write-back only in WB, memory write only in MEM of a store.
  // The branch select follows the live zero flag while in WB.
  always_comb begin
    w_wrf  = 1'b0;
    w_wdm  = 1'b0;
    w_sIn0 = 1'b0;
    if (w_inWb) begin
      w_wrf  = (w_opc == OPC_AR) || (w_opc == OPC_ADDI) ||
               (w_opc == OPC_ORI) || (w_opc == OPC_LW);
      w_sIn0 = ((w_opc == OPC_BEQ) && bus.zero) ||
               ((w_opc == OPC_BNE) && !bus.zero);
    end
    if (r_state == S_MEM)
      w_wdm = (w_opc == OPC_SW);
  end

`ifdef CTRL_ILLEGAL_HALT_EN
  assign w_halted = (r_state == S_HALT);
`else
  assign w_halted = 1'b0;
`endif

  assign bus.op         = w_op;
  assign bus.sIn1_Alu   = w_sIn1;
  assign bus.sIn2_Alu   = w_sIn2;
  assign bus.sWn_Rf     = w_sWn;
  assign bus.sWd_Rf     = w_sWd;
  assign bus.sRn2_Rf    = w_sRn2;
  assign bus.sIn0_Mux   = w_sIn0;
  assign bus.sIn_Pc     = w_sInPc;
  assign bus.sExt10     = w_sExt10;
  assign bus.wrf        = w_wrf;
  assign bus.wdm        = w_wdm;
  assign bus.store      = w_inWb;
  assign bus.instr_done = w_inWb;
  assign bus.halted     = w_halted;

endmodule
